// File: rtl/pe_array_pkg.sv
// Shared constants and helpers for the joined PE array.
// Options: PE_ARRAY_PERF_EN adds stall counters to pe_array_q.
package pe_array_pkg;

    localparam int PE_ACTS  = 4;
    localparam int ACT_W    = 16;
    localparam int PE_WBITS = 256;
    localparam int PE_OBITS = 256;
    localparam int PE_ABITS = PE_ACTS * ACT_W;

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < depth) w++;
        end
        return w + 1;
    endfunction

endpackage

// File: rtl/pe16.sv
// Single PE lane: 16 outputs, each a 4-term MAC of acts by signed int4.
// One result register; results leave in acceptance order.
module pe16
    import pe_array_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PE_ABITS-1:0] in_fp16_acts,
    input  logic [PE_WBITS-1:0] in_int4s,
    output logic                out_valid_vec,
    input  logic                out_ready,
    output logic [PE_OBITS-1:0] out_fp16s
);

    logic                vld;
    logic [PE_OBITS-1:0] res;
    logic [PE_OBITS-1:0] mac;
    logic                accept;

    assign in_ready      = ~vld | out_ready;
    assign accept        = in_valid & in_ready;
    assign out_valid_vec = vld;
    assign out_fp16s     = res;

    // Output j sums act k times sign-extended weight nibble j*4+k.
    always_comb begin
        mac = '0;
        for (int j = 0; j < 16; j++) begin
            logic [15:0] acc;
            logic [3:0]  w;
            acc = '0;
            for (int k = 0; k < PE_ACTS; k++) begin
                w   = in_int4s[(j*PE_ACTS+k)*4 +: 4];
                acc = acc + in_fp16_acts[k*ACT_W +: ACT_W]
                          * {{12{w[3]}}, w};
            end
            mac[j*16 +: 16] = acc;
        end
    end

    // Single-entry result register with handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= 1'b0;
        end else if (accept) begin
            vld <= 1'b1;
        end else if (out_ready) begin
            vld <= 1'b0;
        end
    end

    // Result payload, unreset.
    always_ff @(posedge clk) begin
        if (accept) res <= mac;
    end

endmodule

// File: rtl/pe_lane_fifo.sv
// Synchronous FIFO with occupancy count; used for lane results and masks.
// DEPTH must be a power of two, at least 2.
module pe_lane_fifo
    import pe_array_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            din,
    output logic [W-1:0]            dout,
    output logic                    full,
    output logic                    empty,
    output logic [cnt_w(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, unreset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/pe_array_q.sv
// N_PE pe16 lanes behind one input handshake and one joined output.
// Options: PE_ARRAY_PERF_EN adds perf_in_stall / perf_out_stall.
module pe_array_q
    import pe_array_pkg::*;
#(
    parameter int N_PE       = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_PE-1:0]          in_lane_mask,
    input  logic [N_PE*PE_ABITS-1:0] in_fp16_acts,
    input  logic [N_PE*PE_WBITS-1:0] in_int4s,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_PE-1:0]          out_lane_mask,
    output logic [N_PE*PE_OBITS-1:0] out_fp16s,
    output logic                     err_sticky
`ifdef PE_ARRAY_PERF_EN
    ,
    output logic [31:0]              perf_in_stall,
    output logic [31:0]              perf_out_stall
`endif
);

    localparam int CW = cnt_w(FIFO_DEPTH);

    logic [CW-1:0]       outstanding;
    logic                in_fire;
    logic                out_fire;
    logic                lanes_ok;
    logic [N_PE-1:0]     pe_valid;
    logic [N_PE-1:0]     pe_in_ready;
    logic [N_PE-1:0]     pe_out_valid;
    logic [N_PE-1:0]     pe_out_ready;
    logic [PE_OBITS-1:0] pe_out [N_PE];
    logic [N_PE-1:0]     lane_full;
    logic [N_PE-1:0]     lane_empty;
    logic [CW-1:0]       lane_cnt [N_PE];
    logic [PE_OBITS-1:0] lane_head [N_PE];
    logic [CW-1:0]       named [N_PE];
    logic [N_PE-1:0]     head_mask;
    logic                mask_empty;
    logic                mask_full;
    logic [CW-1:0]       mask_cnt;
    logic                mask_unused;
    logic                err_now;

    assign lanes_ok = &(pe_in_ready | ~in_lane_mask);
    assign in_ready = rst_n & (outstanding < CW'(FIFO_DEPTH)) & lanes_ok;
    assign in_fire  = in_valid & in_ready;
    assign pe_valid = {N_PE{in_fire}} & in_lane_mask;
    assign out_valid = ~mask_empty & (&(~lane_empty | ~head_mask));
    assign out_fire  = out_valid & out_ready;
    assign out_lane_mask = out_valid ? head_mask : '0;
    assign pe_out_ready  = ~lane_full;
    assign mask_unused   = ^{mask_full, mask_cnt};

    // Credit counter bounding transactions in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    pe_lane_fifo #(
        .W     (N_PE),
        .DEPTH (FIFO_DEPTH)
    ) u_mask_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_fire),
        .pop   (out_fire),
        .din   (in_lane_mask),
        .dout  (head_mask),
        .full  (mask_full),
        .empty (mask_empty),
        .count (mask_cnt)
    );

    for (genvar i = 0; i < N_PE; i++) begin : g_lane
        pe16 u_pe (
            .clk           (clk),
            .rst_n         (rst_n),
            .in_valid      (pe_valid[i]),
            .in_ready      (pe_in_ready[i]),
            .in_fp16_acts  (in_fp16_acts[i*PE_ABITS +: PE_ABITS]),
            .in_int4s      (in_int4s[i*PE_WBITS +: PE_WBITS]),
            .out_valid_vec (pe_out_valid[i]),
            .out_ready     (pe_out_ready[i]),
            .out_fp16s     (pe_out[i])
        );

        pe_lane_fifo #(
            .W     (PE_OBITS),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (pe_out_valid[i] & ~lane_full[i]),
            .pop   (out_fire & head_mask[i]),
            .din   (pe_out[i]),
            .dout  (lane_head[i]),
            .full  (lane_full[i]),
            .empty (lane_empty[i]),
            .count (lane_cnt[i])
        );

        // Queued masks that name this lane, for the overrun check.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                named[i] <= '0;
            end else begin
                case ({in_fire & in_lane_mask[i], out_fire & head_mask[i]})
                    2'b10:   named[i] <= named[i] + CW'(1);
                    2'b01:   named[i] <= named[i] - CW'(1);
                    default: named[i] <= named[i];
                endcase
            end
        end
    end

    // Joined output: lanes outside the head mask read as zero.
    always_comb begin
        out_fp16s = '0;
        for (int i = 0; i < N_PE; i++) begin
            if (out_valid && head_mask[i]) begin
                out_fp16s[i*PE_OBITS +: PE_OBITS] = lane_head[i];
            end
        end
    end

    // Lane push into full FIFO, or lane ahead of its queued masks.
    always_comb begin
        err_now = |(pe_out_valid & lane_full);
        for (int i = 0; i < N_PE; i++) begin
            if (lane_cnt[i] > named[i]) err_now = 1'b1;
        end
    end

    // Protocol error latch, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (err_now) begin
            err_sticky <= 1'b1;
        end
    end

`ifdef PE_ARRAY_PERF_EN
    // Saturating stall counters for both handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_in_stall  <= '0;
            perf_out_stall <= '0;
        end else begin
            if (in_valid && !in_ready && perf_in_stall != '1) begin
                perf_in_stall <= perf_in_stall + 32'd1;
            end
            if (out_valid && !out_ready && perf_out_stall != '1) begin
                perf_out_stall <= perf_out_stall + 32'd1;
            end
        end
    end
`else
    // Stall counters compiled out.
`endif

endmodule

// File: tb/tb_pe_array_q.sv
// Directed self-checking bench for pe_array_q (16 lanes, depth 4).
// Expected lane results come from an independent integer MAC model.
module tb_pe_array_q;

    localparam int NP = 16;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [NP-1:0]     in_lane_mask;
    logic [NP*64-1:0]  in_fp16_acts;
    logic [NP*256-1:0] in_int4s;
    logic              out_valid;
    logic              out_ready;
    logic [NP-1:0]     out_lane_mask;
    logic [NP*256-1:0] out_fp16s;
    logic              err_sticky;
`ifdef PE_ARRAY_PERF_EN
    logic [31:0]       perf_in_stall;
    logic [31:0]       perf_out_stall;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    pe_array_q #(.N_PE(NP), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_lane_mask  (in_lane_mask),
        .in_fp16_acts  (in_fp16_acts),
        .in_int4s      (in_int4s),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_lane_mask (out_lane_mask),
        .out_fp16s     (out_fp16s),
        .err_sticky    (err_sticky)
`ifdef PE_ARRAY_PERF_EN
        ,
        .perf_in_stall (perf_in_stall),
        .perf_out_stall(perf_out_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mk_acts(int lane, int seed);
        return {16'(seed*7 + lane + 4), 16'(seed*5 + lane*3 + 3),
                16'(lane + 2), 16'(seed + lane + 1)};
    endfunction

    function automatic logic [255:0] mk_w(int lane, int seed);
        logic [31:0] x;
        x = (32'(seed) * 32'h9E3779B1) ^ (32'(lane) * 32'h01000193);
        return {8{x}};
    endfunction

    function automatic logic [255:0] model(logic [63:0] a, logic [255:0] w);
        logic [255:0] r;
        int acc, av, wv;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            acc = 0;
            for (int k = 0; k < 4; k++) begin
                av = int'(a[k*16 +: 16]);
                wv = int'(w[(j*4+k)*4 +: 4]);
                if (wv > 7) wv = wv - 16;
                acc = acc + av * wv;
            end
            r[j*16 +: 16] = acc[15:0];
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(int seed);
        for (int i = 0; i < NP; i++) begin
            in_fp16_acts[i*64 +: 64] = mk_acts(i, seed);
            in_int4s[i*256 +: 256]   = mk_w(i, seed);
        end
    endtask

    task automatic send(logic [NP-1:0] m);
        bit done;
        done = 0;
        in_lane_mask = m;
        in_valid = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            if (in_ready) done = 1;
            tick();
        end
        in_valid = 1'b0;
        chk("send_accepted", 256'(done), 256'd1);
    endtask

    task automatic wait_out();
        for (int c = 0; c < 20 && !out_valid; c++) tick();
        chk("out_arrives", 256'(out_valid), 256'd1);
    endtask

    task automatic chk_out(logic [NP-1:0] m, int seed, string tag);
        logic [255:0] e;
        chk({tag, "_valid"}, 256'(out_valid), 256'd1);
        chk({tag, "_mask"}, 256'(out_lane_mask), 256'(m));
        for (int i = 0; i < NP; i++) begin
            e = m[i] ? model(mk_acts(i, seed), mk_w(i, seed)) : '0;
            chk($sformatf("%s_lane%0d", tag, i),
                out_fp16s[i*256 +: 256], e);
        end
    endtask

    initial begin
        int acc;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_lane_mask = '0;
        in_fp16_acts = '0;
        in_int4s = '0;
        repeat (3) tick();
        chk("rst_in_ready", 256'(in_ready), 256'd0);
        chk("rst_out_valid", 256'(out_valid), 256'd0);
        chk("rst_out_mask", 256'(out_lane_mask), 256'd0);
        chk("rst_out_zero", 256'(out_fp16s == '0), 256'd1);
        chk("rst_err", 256'(err_sticky), 256'd0);

        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 256'(in_ready), 256'd1);
        chk("rel_outstanding", 256'(dut.outstanding), 256'd0);

        // Full mask, single result pulse.
        out_ready = 1'b1;
        load(1);
        send(16'hFFFF);
        chk("t1_lat_valid", 256'(out_valid), 256'd0);
        chk("t1_outstanding1", 256'(dut.outstanding), 256'd1);
        tick();
        chk_out(16'hFFFF, 1, "t1");
        tick();
        chk("t1_pulse_end", 256'(out_valid), 256'd0);
        chk("t1_outstanding0", 256'(dut.outstanding), 256'd0);
        tick();
        chk("t1_no_repeat", 256'(out_valid), 256'd0);

        // Literal vector: acts 1,2,3,4 times weight -1 gives -10.
        in_fp16_acts = '0;
        in_int4s = '0;
        in_fp16_acts[63:0] = {16'd4, 16'd3, 16'd2, 16'd1};
        in_int4s[255:0] = {64{4'hF}};
        send(16'h0001);
        tick();
        chk("lit_valid", 256'(out_valid), 256'd1);
        chk("lit_lane0", out_fp16s[255:0], {16{16'hFFF6}});
        chk("lit_lane1", out_fp16s[511:256], 256'd0);
        tick();

        // Sparse mask: only lanes 0 and 2 see a valid.
        load(2);
        in_lane_mask = 16'h0005;
        in_valid = 1'b1;
        #1;
        chk("t2_pe_valid", 256'(dut.pe_valid), 256'h0005);
        send(16'h0005);
        wait_out();
        chk_out(16'h0005, 2, "t2");
        tick();

        // All-zero mask resolves the cycle after in_fire.
        load(3);
        send(16'h0000);
        chk("z_valid", 256'(out_valid), 256'd1);
        chk("z_mask", 256'(out_lane_mask), 256'd0);
        chk("z_data", 256'(out_fp16s == '0), 256'd1);
        tick();
        chk("z_popped", 256'(out_valid), 256'd0);

        // Backpressure: 6 offered, 4 accepted.
        out_ready = 1'b0;
        acc = 0;
        load(10);
        in_lane_mask = 16'hFFFF;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (in_ready && acc < 6) begin
                acc++;
                tick();
                load(10 + acc);
            end else begin
                tick();
            end
        end
        chk("bp_accepted", 256'(acc), 256'd4);
        chk("bp_in_ready", 256'(in_ready), 256'd0);
        in_valid = 1'b0;
        chk_out(16'hFFFF, 10, "bp0");
        tick();
        chk_out(16'hFFFF, 10, "bp0_hold");
        out_ready = 1'b1;
        #1;
        chk("bp_no_passthru", 256'(in_ready), 256'd0);
        tick();
        chk("bp_credit_back", 256'(in_ready), 256'd1);
        chk_out(16'hFFFF, 11, "bp1");
        tick();
        chk_out(16'hFFFF, 12, "bp2");
        tick();
        chk_out(16'hFFFF, 13, "bp3");
        tick();
        chk("bp_drained", 256'(out_valid), 256'd0);
        chk("bp_outstanding", 256'(dut.outstanding), 256'd0);

        // Zero mask sandwiched between full masks.
        out_ready = 1'b0;
        load(20);
        send(16'hFFFF);
        load(21);
        send(16'h0000);
        load(22);
        send(16'hFFFF);
        wait_out();
        tick();
        tick();
        chk_out(16'hFFFF, 20, "sw0");
        out_ready = 1'b1;
        tick();
        chk_out(16'h0000, 21, "sw1");
        tick();
        chk_out(16'hFFFF, 22, "sw2");
        tick();
        chk("sw_drained", 256'(out_valid), 256'd0);

        // Reset with three in flight.
        out_ready = 1'b0;
        load(30);
        send(16'hFFFF);
        load(31);
        send(16'h00FF);
        load(32);
        send(16'hFFFF);
        tick();
        chk("mr_outstanding3", 256'(dut.outstanding), 256'd3);
        rst_n = 1'b0;
        tick();
        chk("mr_in_ready", 256'(in_ready), 256'd0);
        chk("mr_out_valid", 256'(out_valid), 256'd0);
        chk("mr_out_mask", 256'(out_lane_mask), 256'd0);
        chk("mr_out_zero", 256'(out_fp16s == '0), 256'd1);
        chk("mr_outstanding0", 256'(dut.outstanding), 256'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("mr_no_stale", 256'(out_valid), 256'd0);
        out_ready = 1'b1;
        load(40);
        send(16'h00F0);
        wait_out();
        chk_out(16'h00F0, 40, "mr_fresh");
        tick();
        chk("mr_fresh_done", 256'(out_valid), 256'd0);

`ifdef PE_ARRAY_PERF_EN
        begin
            logic [31:0] p0;
            out_ready = 1'b0;
            load(50);
            send(16'h0001);
            wait_out();
            p0 = perf_out_stall;
            repeat (5) tick();
            chk("perf_out_5", 256'(perf_out_stall - p0), 256'd5);
            @(negedge clk);
            dut.perf_out_stall = 32'hFFFF_FFFE;
            repeat (3) tick();
            chk("perf_out_sat", 256'(perf_out_stall), 256'hFFFF_FFFF);
            out_ready = 1'b1;
            tick();
        end
`endif

        chk("final_err", 256'(err_sticky), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_array_q.md
# pe_array_q

Parametrised successor of the 16-lane PE array. It replicates `N_PE` `pe16` lanes that share one input handshake. Each lane gets a per-transaction enable mask and a per-lane result FIFO. A single joined output handshake releases one transaction's results only when every enabled lane has produced them. It sits between the activation/weight dispatcher and the FP16 result writeback, replacing the per-lane `out_valid_vec` scheme that let lanes drift out of alignment.

## Interface
Parameters:
- `N_PE`, 16, number of `pe16` lanes (1..32).
- `FIFO_DEPTH`, 4, per-lane result FIFO depth and maximum outstanding transactions (power of 2, ≥2).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: transaction offered.
- `in_ready` out 1: transaction accepted when `in_valid & in_ready` (in_fire).
- `in_lane_mask` in `N_PE`: lanes participating in this transaction; sampled on in_fire.
- `in_fp16_acts` in `N_PE*64`: lane i takes bits [i*64 +: 64], act0 in the LSBs.
- `in_int4s` in `N_PE*256`: lane i takes weights [i*256 +: 256].
- `out_valid` out 1: joined result available.
- `out_ready` in 1: result consumed when `out_valid & out_ready` (out_fire).
- `out_lane_mask` out `N_PE`: mask of the transaction at the output head.
- `out_fp16s` out `N_PE*256`: lane i result at [i*256 +: 256].
- `err_sticky` out 1: protocol error flag; cleared only by reset.

## Operation
- Lane i `pe16.in_valid = in_fire & in_lane_mask[i]`. Disabled lanes see no valid. Data is wired straight through.
- `in_ready = (outstanding < FIFO_DEPTH) & AND over i of (pe_in_ready[i] | ~in_lane_mask[i])`.
- `pe16.in_ready` must not depend on `pe16.in_valid`. Each `pe16` must return results in acceptance order.
- `outstanding`: counter of width clog2(FIFO_DEPTH)+1. Increments on in_fire, decrements on out_fire, and holds when both occur in the same cycle.
- Mask FIFO, depth `FIFO_DEPTH`: on in_fire, pushes `in_lane_mask`.
- Lane FIFO i: pushes `pe16.out_fp16s` when `pe16.out_valid_vec` is high and the FIFO is not full. `pe16.out_ready = ~lane_full[i]`.
- `out_valid` = mask FIFO not empty & every lane set in the head mask has a non-empty lane FIFO.
- `out_fp16s`:
  - lane i = lane FIFO head when `out_valid` and head-mask bit i is set;
  - otherwise 0;
  - all zeros whenever `out_valid` = 0.
- `out_lane_mask` = head mask when `out_valid`, else 0.
- out_fire pops the mask FIFO and the lane FIFOs of every lane set in the head mask.
- All-zero mask is legal. The transaction occupies one credit and yields `out_valid` with all-zero data and an all-zero mask.
- `err_sticky` sets on either of these:
  - a lane asserts `out_valid_vec` while its FIFO is full;
  - a lane FIFO holds more entries than the mask FIFO has entries naming that lane.

  The credit limit makes both impossible with a compliant `pe16`.

## Timing
- Reset values: `in_ready` 0 during reset. `out_valid` 0, `out_lane_mask` 0, `out_fp16s` 0, `err_sticky` 0. All FIFOs empty, `outstanding` 0.
- First cycle after reset release: `in_ready` reflects the PE readies.
- Latency: a lane FIFO push is visible the cycle after `pe16.out_valid_vec`. `out_valid` rises the cycle after the last enabled lane's result (`pe16` latency + 1). An all-zero mask gives `out_valid` the cycle after in_fire.
- `in_ready` derives from the registered `outstanding`. An out_fire at full occupancy frees a credit only from the next cycle. There is no same-cycle pass-through.
- Output is registered-FIFO-head based. `out_valid` and data hold stable while `out_ready` = 0.
- Reset asserted mid-operation discards all outstanding transactions and FIFO contents on that edge. The `pe16` lanes are reset by the same `rst_n`.

## Configuration
- `PE_ARRAY_PERF_EN` defined adds two 32-bit saturating counters, reset to 0:
  - port `perf_in_stall` counts cycles with `in_valid & ~in_ready`;
  - port `perf_out_stall` counts cycles with `out_valid & ~out_ready`.
- `PE_ARRAY_PERF_EN` undefined: the ports and counters do not exist. Functional behaviour is identical.

## Structure
- `pe_array_pkg` holds:
  - constants `PE_ACTS` = 4, `ACT_W` = 16, `PE_WBITS` = 256, `PE_OBITS` = 256;
  - a function returning the counter width for `FIFO_DEPTH`.
- One sub-module, `pe_lane_fifo`: synchronous FIFO parametrised in width and depth, with push, pop, full, empty and count. It is used for the lane FIFOs and for the mask FIFO.
- `pe16` is instantiated unchanged, one per lane.

## Test plan
- Reset, then one transaction with mask 0xFFFF and distinct per-lane data → exactly one `out_valid` pulse carrying all 16 lane results, `out_lane_mask` = 0xFFFF, `outstanding` back to 0.
- Mask 0x0005 → only lanes 0 and 2 see `pe16.in_valid`. Output lanes 0 and 2 carry results, other lanes are 0, `out_lane_mask` = 0x0005.
- Hold `out_ready` = 0 and offer 6 transactions → 4 accepted and `in_ready` drops. Raise `out_ready` → 4 results in order; `in_ready` returns the cycle after the first out_fire.
- All-zero mask between two full-mask transactions → three results in order, the middle one with zero mask and zero data.
- Assert `rst_n` = 0 for one cycle with 3 transactions outstanding → all outputs 0 next cycle and no stale result afterwards. A fresh transaction completes normally and `err_sticky` stays 0.
- With `PE_ARRAY_PERF_EN`: 5 cycles of `out_valid & ~out_ready` → `perf_out_stall` = 5. Preloading near 2^32−1 shows saturation.
